// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Brief    : Shared types, address map and lane helpers for the MMIO LSU.
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // RV32 load/store width and sign codes
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } lsu_func3_e;

    // Coarse decode result for an address
    typedef enum logic [1:0] {
        R_DMEM = 2'd0,
        R_PER  = 2'd1,
        R_SW   = 2'd2,
        R_NONE = 2'd3
    } lsu_region_e;

    // Address map
    localparam logic [11:0] c_dmem_base  = 12'h000;
    localparam logic [11:0] c_dmem_span  = 12'h800;
    localparam logic [11:0] c_hex_base   = 12'h800;
    localparam logic [11:0] c_hex_stride = 12'h010;
    localparam logic [11:0] c_ledr_base  = 12'h880;
    localparam logic [11:0] c_ledg_base  = 12'h890;
    localparam logic [11:0] c_lcd_base   = 12'h8A0;
    localparam logic [11:0] c_sw_base    = 12'h900;

    function automatic logic lsu_func3_legal(input logic [2:0] f3);
        case (f3)
            LB, LH, LW, LBU, LHU: return 1'b1;
            default:              return 1'b0;
        endcase
    endfunction

    // Byte lanes touched by an access at byte offset off
    function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            LB, LBU: return 4'b0001 << off;
            LH, LHU: return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate right-aligned store data across every lane it could land in
    function automatic logic [31:0] lsu_st_lanes(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            LB, LBU: return {4{d[7:0]}};
            LH, LHU: return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Bring the addressed byte/half down to bit 0 and extend it
    function automatic logic [31:0] lsu_ld_extract(input logic [31:0] word, input logic [1:0] off,
                                                   input logic [2:0] f3);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            LB:      return {{24{sh[7]}}, sh[7:0]};
            LBU:     return {24'd0, sh[7:0]};
            LH:      return {{16{sh[15]}}, sh[15:0]};
            LHU:     return {16'd0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    // Byte-wise merge of new data into an old word
    function automatic logic [31:0] lsu_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
        logic [31:0] m;
        m = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_dmem.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_dmem
//  Brief    : Single-port byte-write data RAM with write-first registered read.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_dmem
    import lsu_pkg::*;
#(
    parameter int unsigned DMEM_WORDS = 512,
    parameter int unsigned AW         = 9
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] r_mem [DMEM_WORDS];
    logic [31:0] r_rdata;
    logic [31:0] w_merged;

    // Word as it looks after this cycle's write, so a same-cycle read sees new bytes
    assign w_merged = lsu_merge(r_mem[addr_i], wdata_i, we_i ? be_i : 4'b0000);

    // Byte-lane writes and write-first read register; contents are never reset
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i && be_i[b]) r_mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
            r_rdata <= w_merged;
        end
    end

    assign rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: rtl/lsu_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_mmio
//  Brief    : RV32 load/store unit: DMEM, output peripheral registers and a
//             synchronised switch input, with one-cycle registered response.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_mmio
    import lsu_pkg::*;
#(
    parameter int unsigned DMEM_WORDS = 512,
    parameter int unsigned N_HEX      = 8,
    parameter int unsigned SW_SYNC    = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [11:0]          addr_i,
    input  logic [2:0]           func3_i,
    input  logic [31:0]          st_data_i,
    input  logic [31:0]          io_sw_i,
    output logic                 ack_o,
    output logic                 err_o,
    output logic [31:0]          ld_data_o,
    output logic [N_HEX*32-1:0]  io_hex_o,
    output logic [31:0]          io_ledr_o,
    output logic [31:0]          io_ledg_o,
    output logic [31:0]          io_lcd_o
);

    localparam int unsigned c_aw     = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
    localparam int unsigned c_per_n  = N_HEX + 3;   // HEX[0..N-1], LEDR, LEDG, LCD
    localparam logic [3:0]  c_ledr_i = 4'(N_HEX);
    localparam logic [3:0]  c_ledg_i = 4'(N_HEX + 1);
    localparam logic [3:0]  c_lcd_i  = 4'(N_HEX + 2);

    logic [31:0]              r_per [c_per_n];
    logic [SW_SYNC-1:0][31:0] r_sw_sync;
    logic                     r_arm;
    logic                     r_ack, r_err, r_ld_ok, r_from_dmem;
    logic [2:0]               r_func3;
    logic [1:0]               r_off;
    logic [31:0]              r_per_rdata;

    lsu_region_e w_region;
    logic [3:0]  w_per_idx;
    logic [11:0] w_hex_off;
    logic        w_misalign, w_fault, w_accept, w_ok;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_per_rd, w_dmem_rdata;

    assign w_hex_off = addr_i - c_hex_base;

    // Address decode into region and peripheral register index
    always_comb begin
        w_region  = R_NONE;
        w_per_idx = 4'd0;
        if ((addr_i - c_dmem_base) < c_dmem_span) begin
            w_region = R_DMEM;
        end else if (w_hex_off < c_hex_stride * 12'(N_HEX) && w_hex_off[3:2] == 2'b00) begin
            w_region  = R_PER;
            w_per_idx = {1'b0, w_hex_off[6:4]};
        end else if (addr_i[11:2] == c_ledr_base[11:2]) begin
            w_region  = R_PER;
            w_per_idx = c_ledr_i;
        end else if (addr_i[11:2] == c_ledg_base[11:2]) begin
            w_region  = R_PER;
            w_per_idx = c_ledg_i;
        end else if (addr_i[11:2] == c_lcd_base[11:2]) begin
            w_region  = R_PER;
            w_per_idx = c_lcd_i;
        end else if (addr_i[11:2] == c_sw_base[11:2]) begin
            w_region = R_SW;
        end
    end

    assign w_misalign = ((func3_i == LH || func3_i == LHU) && addr_i[0]) ||
                        (func3_i == LW && addr_i[1:0] != 2'b00);
    assign w_fault    = w_misalign || !lsu_func3_legal(func3_i) || (w_region == R_NONE) ||
                        (we_i && w_region == R_SW);
    // r_arm masks the edge on which reset is released
    assign w_accept   = req_i && r_arm;
    assign w_ok       = w_accept && !w_fault;
    assign w_be       = lsu_byte_en(func3_i, addr_i[1:0]);
    assign w_wdata    = lsu_st_lanes(func3_i, st_data_i);

    // Peripheral / switch read selection for the response register
    always_comb begin
        w_per_rd = 32'd0;
        if (w_region == R_SW) begin
            w_per_rd = r_sw_sync[SW_SYNC-1];
        end else begin
            for (int i = 0; i < int'(c_per_n); i++) begin
                if (w_per_idx == 4'(i)) w_per_rd = r_per[i];
            end
        end
    end

    lsu_dmem #(
        .DMEM_WORDS (DMEM_WORDS),
        .AW         (c_aw)
    ) u_dmem (
        .clk_i   (clk_i),
        .en_i    (w_ok && w_region == R_DMEM),
        .we_i    (we_i),
        .be_i    (w_be),
        .addr_i  (addr_i[2 +: c_aw]),
        .wdata_i (w_wdata),
        .rdata_o (w_dmem_rdata)
    );

    // Peripheral register file with byte-lane stores
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(c_per_n); i++) r_per[i] <= 32'd0;
        end else if (w_ok && we_i && w_region == R_PER) begin
            for (int i = 0; i < int'(c_per_n); i++) begin
                if (w_per_idx == 4'(i)) r_per[i] <= lsu_merge(r_per[i], w_wdata, w_be);
            end
        end
    end

    // Switch input synchroniser chain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_sw_sync <= '0;
        else         r_sw_sync <= {r_sw_sync[SW_SYNC-2:0], io_sw_i};
    end

    // Response register: ack/err for every accepted request, load context
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_arm       <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_ld_ok     <= 1'b0;
            r_from_dmem <= 1'b0;
            r_func3     <= 3'd0;
            r_off       <= 2'd0;
            r_per_rdata <= 32'd0;
        end else begin
            r_arm       <= 1'b1;
            r_ack       <= w_accept;
            r_err       <= w_accept && w_fault;
            r_ld_ok     <= w_ok && !we_i;
            r_from_dmem <= (w_region == R_DMEM);
            r_func3     <= func3_i;
            r_off       <= addr_i[1:0];
            if (w_ok && !we_i) r_per_rdata <= w_per_rd;
        end
    end

    assign ack_o     = r_ack;
    assign err_o     = r_err;
    assign ld_data_o = r_ld_ok ? lsu_ld_extract(r_from_dmem ? w_dmem_rdata : r_per_rdata,
                                                r_off, r_func3)
                               : 32'd0;

    generate
        for (genvar i = 0; i < int'(N_HEX); i++) begin : g_hex
            assign io_hex_o[32*i +: 32] = r_per[i];
        end
    endgenerate

    assign io_ledr_o = r_per[N_HEX];
    assign io_ledg_o = r_per[N_HEX + 1];
    assign io_lcd_o  = r_per[N_HEX + 2];

endmodule
`default_nettype wire

// File: tb/tb_lsu_mmio.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_lsu_mmio
//  Brief    : Directed self-checking bench for lsu_mmio.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mmio;

    localparam int unsigned N_HEX      = 8;
    localparam int unsigned SW_SYNC    = 2;
    localparam int unsigned DMEM_WORDS = 512;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic                clk_i = 1'b0;
    logic                rst_ni = 1'b0;
    logic                req_i = 1'b0;
    logic                we_i = 1'b0;
    logic [11:0]         addr_i = '0;
    logic [2:0]          func3_i = '0;
    logic [31:0]         st_data_i = '0;
    logic [31:0]         io_sw_i = '0;
    logic                ack_o, err_o;
    logic [31:0]         ld_data_o, io_ledr_o, io_ledg_o, io_lcd_o;
    logic [N_HEX*32-1:0] io_hex_o;

    int n_checks = 0;
    int n_errors = 0;

    logic        s_ack, s_err;
    logic [31:0] s_ld;

    lsu_mmio #(
        .DMEM_WORDS (DMEM_WORDS),
        .N_HEX      (N_HEX),
        .SW_SYNC    (SW_SYNC)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (req_i),
        .we_i      (we_i),
        .addr_i    (addr_i),
        .func3_i   (func3_i),
        .st_data_i (st_data_i),
        .io_sw_i   (io_sw_i),
        .ack_o     (ack_o),
        .err_o     (err_o),
        .ld_data_o (ld_data_o),
        .io_hex_o  (io_hex_o),
        .io_ledr_o (io_ledr_o),
        .io_ledg_o (io_ledg_o),
        .io_lcd_o  (io_lcd_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One isolated access: drive on a falling edge, capture response one cycle later
    task automatic access(input logic we, input logic [11:0] a, input logic [2:0] f3,
                          input logic [31:0] d);
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; addr_i = a; func3_i = f3; st_data_i = d;
        @(negedge clk_i);
        s_ack = ack_o; s_err = err_o; s_ld = ld_data_o;
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic err, input logic [31:0] ld);
        check({tag, ".ack"}, 256'(s_ack), 256'(1'b1));
        check({tag, ".err"}, 256'(s_err), 256'(err));
        check({tag, ".ld"},  256'(s_ld),  256'(ld));
    endtask

    task automatic check_io(input string tag, input logic [255:0] hex, input logic [31:0] ledr,
                            input logic [31:0] ledg, input logic [31:0] lcd);
        check({tag, ".hex"},  256'(io_hex_o),  hex);
        check({tag, ".ledr"}, 256'(io_ledr_o), 256'(ledr));
        check({tag, ".ledg"}, 256'(io_ledg_o), 256'(ledg));
        check({tag, ".lcd"},  256'(io_lcd_o),  256'(lcd));
    endtask

    typedef struct {
        logic        we;
        logic [11:0] a;
        logic [2:0]  f3;
        logic [31:0] d;
    } acc_t;

    acc_t        faults[12];
    logic [255:0] hex_exp;
    int          first_seen;
    int          ack_cnt;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst.ack", 256'(ack_o), 256'(0));
        check("rst.err", 256'(err_o), 256'(0));
        check("rst.ld",  256'(ld_data_o), 256'(0));
        check_io("rst", 256'(0), 32'd0, 32'd0, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i);

        access(1'b0, 12'h880, F_W, 32'd0);
        expect_resp("lw_ledr_rst", 1'b0, 32'd0);
        check_io("post_rst", 256'(0), 32'd0, 32'd0, 32'd0);

        // ---------------- DMEM byte lanes ----------------
        access(1'b1, 12'h004, F_W, 32'h11223344);  expect_resp("sw_004", 1'b0, 32'd0);
        access(1'b1, 12'h005, F_B, 32'h000000AA);  expect_resp("sb_005", 1'b0, 32'd0);
        access(1'b0, 12'h004, F_W, 32'd0);         expect_resp("lw_004", 1'b0, 32'h1122AA44);
        access(1'b0, 12'h005, F_B, 32'd0);         expect_resp("lb_005", 1'b0, 32'hFFFFFFAA);
        access(1'b0, 12'h005, F_BU, 32'd0);        expect_resp("lbu_005", 1'b0, 32'h000000AA);
        access(1'b0, 12'h004, F_H, 32'd0);         expect_resp("lh_004", 1'b0, 32'hFFFFAA44);
        access(1'b0, 12'h006, F_HU, 32'd0);        expect_resp("lhu_006", 1'b0, 32'h00001122);
        access(1'b0, 12'h007, F_B, 32'd0);         expect_resp("lb_007", 1'b0, 32'h00000011);

        // ---------------- peripherals ----------------
        access(1'b1, 12'h822, F_H, 32'h0000BEEF);  expect_resp("sh_822", 1'b0, 32'd0);
        hex_exp = 256'h0;
        hex_exp[95:64] = 32'hBEEF0000;
        check("hex2_after_sh", 256'(io_hex_o), hex_exp);
        access(1'b0, 12'h822, F_HU, 32'd0);        expect_resp("lhu_822", 1'b0, 32'h0000BEEF);
        access(1'b0, 12'h822, F_H, 32'd0);         expect_resp("lh_822", 1'b0, 32'hFFFFBEEF);
        access(1'b0, 12'h820, F_W, 32'd0);         expect_resp("lw_820", 1'b0, 32'hBEEF0000);
        access(1'b1, 12'h870, F_W, 32'h01020304);  expect_resp("sw_870", 1'b0, 32'd0);
        hex_exp[255:224] = 32'h01020304;
        access(1'b1, 12'h880, F_W, 32'hCAFEF00D);  expect_resp("sw_ledr", 1'b0, 32'd0);
        access(1'b1, 12'h893, F_B, 32'h0000007E);  expect_resp("sb_ledg", 1'b0, 32'd0);
        access(1'b1, 12'h8A0, F_W, 32'h12345678);  expect_resp("sw_lcd", 1'b0, 32'd0);
        check_io("per", hex_exp, 32'hCAFEF00D, 32'h7E000000, 32'h12345678);
        access(1'b0, 12'h893, F_B, 32'd0);         expect_resp("lb_893", 1'b0, 32'h0000007E);
        access(1'b0, 12'h882, F_H, 32'd0);         expect_resp("lh_882", 1'b0, 32'hFFFFCAFE);

        // ---------------- faults change nothing ----------------
        faults[0]  = '{1'b0, 12'h006, F_W, 32'd0};
        faults[1]  = '{1'b1, 12'h003, F_H, 32'h0000FFFF};
        faults[2]  = '{1'b1, 12'h900, F_W, 32'hFFFFFFFF};
        faults[3]  = '{1'b0, 12'hC00, F_W, 32'd0};
        faults[4]  = '{1'b0, 12'h004, 3'b011, 32'd0};
        faults[5]  = '{1'b1, 12'h006, F_W, 32'hDEADBEEF};
        faults[6]  = '{1'b1, 12'h823, F_H, 32'h00001111};
        faults[7]  = '{1'b1, 12'h804, F_W, 32'hFFFFFFFF};
        faults[8]  = '{1'b1, 12'h8A4, F_W, 32'hFFFFFFFF};
        faults[9]  = '{1'b1, 12'h004, 3'b110, 32'hFFFFFFFF};
        faults[10] = '{1'b0, 12'h883, F_HU, 32'd0};
        faults[11] = '{1'b1, 12'h894, F_B, 32'h000000FF};
        for (int i = 0; i < 12; i++) begin
            access(faults[i].we, faults[i].a, faults[i].f3, faults[i].d);
            expect_resp($sformatf("fault%0d", i), 1'b1, 32'd0);
        end
        access(1'b0, 12'h004, F_W, 32'd0);         expect_resp("lw_004_kept", 1'b0, 32'h1122AA44);
        check_io("after_faults", hex_exp, 32'hCAFEF00D, 32'h7E000000, 32'h12345678);

        // ---------------- back-to-back read-after-write ----------------
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; addr_i = 12'h010; func3_i = F_W; st_data_i = 32'hA5A5A5A5;
        @(negedge clk_i);
        check("b2b.st1_ack", 256'(ack_o), 256'(1));
        check("b2b.st1_ld",  256'(ld_data_o), 256'(0));
        addr_i = 12'h011; func3_i = F_B; st_data_i = 32'h0000003C;
        @(negedge clk_i);
        check("b2b.st2_ack", 256'(ack_o), 256'(1));
        we_i = 1'b0; addr_i = 12'h010; func3_i = F_W;
        @(negedge clk_i);
        check("b2b.ld_ack", 256'(ack_o), 256'(1));
        check("b2b.ld",     256'(ld_data_o), 256'(32'hA5A53CA5));
        req_i = 1'b0;
        @(negedge clk_i);
        check("idle.ack", 256'(ack_o), 256'(0));
        check("idle.ld",  256'(ld_data_o), 256'(0));

        // ---------------- switch synchroniser latency ----------------
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; addr_i = 12'h900; func3_i = F_W;
        @(posedge clk_i);
        #1 io_sw_i = 32'h5A5A0000;
        first_seen = -1;
        ack_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (ack_o === 1'b1) ack_cnt++;
            if (first_seen < 0 && ld_data_o === 32'h5A5A0000) first_seen = k;
        end
        req_i = 1'b0;
        check("sw.latency",  256'(first_seen), 256'(SW_SYNC + 1));
        check("sw.ack_cont", 256'(ack_cnt), 256'(8));

        // ---------------- reset during a pending store ack ----------------
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; addr_i = 12'h890; func3_i = F_W; st_data_i = 32'h00000055;
        @(posedge clk_i);
        #1 rst_ni = 1'b0;
        req_i = 1'b0; we_i = 1'b0;
        @(negedge clk_i);
        check("midrst.ack", 256'(ack_o), 256'(0));
        check_io("midrst", 256'(0), 32'd0, 32'd0, 32'd0);

        // ---------------- store on the reset-release edge is ignored ----------------
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; addr_i = 12'h880; func3_i = F_W; st_data_i = 32'hFFFFFFFF;
        @(posedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("relst.ack",  256'(ack_o), 256'(0));
        check("relst.ledr", 256'(io_ledr_o), 256'(0));
        req_i = 1'b0; we_i = 1'b0;
        @(negedge clk_i);
        check("relst.ack2", 256'(ack_o), 256'(0));

        access(1'b0, 12'h890, F_W, 32'd0);         expect_resp("lw_ledg_rst", 1'b0, 32'd0);
        access(1'b0, 12'h004, F_W, 32'd0);         expect_resp("lw_004_norst", 1'b0, 32'h1122AA44);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
